// File: rtl/ex_wb_result_pipe.sv
// EX/MEM and MEM/WB result pipeline feeding the forwarding unit, with load-use
// stall detection and a saturating stall-cycle counter.
module ex_wb_result_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_EX_reg_write,
    input  logic              i_EX_mem_read,
    input  logic [REG_W-1:0]  i_EX_write_register,
    input  logic [DATA_W-1:0] i_EX_alu_result,
    input  logic              i_flush,
    input  logic              i_MEM_stall,
    input  logic [DATA_W-1:0] i_MEM_read_data,
    input  logic [REG_W-1:0]  i_ID_Rs,
    input  logic [REG_W-1:0]  i_ID_Rt,
    output logic              o_EX_MEM_reg_write,
    output logic              o_EX_MEM_mem_read,
    output logic [REG_W-1:0]  o_write_register_MEM,
    output logic [DATA_W-1:0] o_MEM_alu_result,
    output logic              o_MEM_WB_reg_write,
    output logic [REG_W-1:0]  o_write_register_WB,
    output logic [DATA_W-1:0] o_WB_write_data,
    output logic              o_load_use_stall,
    output logic [CNT_W-1:0]  o_stall_cycles
);

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ex_wr_valid_s;
    logic              load_use_s;
    logic              stall_event_s;
    logic [DATA_W-1:0] wb_data_s;

    // Qualify writes ($0 is never a forwarding source) and detect load-use hazards.
    always_comb begin
        ex_wr_valid_s = i_EX_reg_write && (i_EX_write_register != REG_ZERO);
        load_use_s    = i_EX_mem_read && ex_wr_valid_s &&
                        ((i_EX_write_register == i_ID_Rs) ||
                         (i_EX_write_register == i_ID_Rt));
        stall_event_s = load_use_s || i_MEM_stall;
        wb_data_s     = o_EX_MEM_mem_read ? i_MEM_read_data : o_MEM_alu_result;
    end

    assign o_load_use_stall = load_use_s;

    // EX/MEM register: a memory stall outranks a flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_EX_MEM_reg_write   <= 1'b0;
            o_EX_MEM_mem_read    <= 1'b0;
            o_write_register_MEM <= REG_ZERO;
            o_MEM_alu_result     <= {DATA_W{1'b0}};
        end else if (i_MEM_stall) begin
            o_EX_MEM_reg_write   <= o_EX_MEM_reg_write;
            o_EX_MEM_mem_read    <= o_EX_MEM_mem_read;
            o_write_register_MEM <= o_write_register_MEM;
            o_MEM_alu_result     <= o_MEM_alu_result;
        end else if (i_flush) begin
            o_EX_MEM_reg_write   <= 1'b0;
            o_EX_MEM_mem_read    <= 1'b0;
            o_write_register_MEM <= i_EX_write_register;
            o_MEM_alu_result     <= i_EX_alu_result;
        end else begin
            o_EX_MEM_reg_write   <= ex_wr_valid_s;
            o_EX_MEM_mem_read    <= i_EX_mem_read;
            o_write_register_MEM <= i_EX_write_register;
            o_MEM_alu_result     <= i_EX_alu_result;
        end
    end

    // MEM/WB register: a stall issues a bubble so the held load is written back once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_MEM_WB_reg_write  <= 1'b0;
            o_write_register_WB <= REG_ZERO;
            o_WB_write_data     <= {DATA_W{1'b0}};
        end else if (i_MEM_stall) begin
            o_MEM_WB_reg_write  <= 1'b0;
            o_write_register_WB <= o_write_register_WB;
            o_WB_write_data     <= o_WB_write_data;
        end else begin
            o_MEM_WB_reg_write  <= o_EX_MEM_reg_write;
            o_write_register_WB <= o_write_register_MEM;
            o_WB_write_data     <= wb_data_s;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cycles <= {CNT_W{1'b0}};
        end else if (stall_event_s && (o_stall_cycles != CNT_MAX)) begin
            o_stall_cycles <= o_stall_cycles + CNT_ONE;
        end else begin
            o_stall_cycles <= o_stall_cycles;
        end
    end

endmodule

// File: tb/tb_ex_wb_result_pipe.sv
// Directed bench for ex_wb_result_pipe; writeback results are predicted into a
// scoreboard queue when an instruction is issued and popped when it reaches WB.
module tb_ex_wb_result_pipe;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_EX_reg_write, i_EX_mem_read, i_flush, i_MEM_stall;
    logic [REG_W-1:0]  i_EX_write_register, i_ID_Rs, i_ID_Rt;
    logic [DATA_W-1:0] i_EX_alu_result, i_MEM_read_data;
    logic              o_EX_MEM_reg_write, o_EX_MEM_mem_read, o_MEM_WB_reg_write, o_load_use_stall;
    logic [REG_W-1:0]  o_write_register_MEM, o_write_register_WB;
    logic [DATA_W-1:0] o_MEM_alu_result, o_WB_write_data;
    logic [CNT_W-1:0]  o_stall_cycles;

    typedef struct packed {
        logic              rw;
        logic [REG_W-1:0]  wr;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t wb_q[$];
    int  total   = 0;
    int  bad     = 0;
    int  cnt_exp = 0;

    ex_wb_result_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_EX_reg_write(i_EX_reg_write), .i_EX_mem_read(i_EX_mem_read),
        .i_EX_write_register(i_EX_write_register), .i_EX_alu_result(i_EX_alu_result),
        .i_flush(i_flush), .i_MEM_stall(i_MEM_stall), .i_MEM_read_data(i_MEM_read_data),
        .i_ID_Rs(i_ID_Rs), .i_ID_Rt(i_ID_Rt),
        .o_EX_MEM_reg_write(o_EX_MEM_reg_write), .o_EX_MEM_mem_read(o_EX_MEM_mem_read),
        .o_write_register_MEM(o_write_register_MEM), .o_MEM_alu_result(o_MEM_alu_result),
        .o_MEM_WB_reg_write(o_MEM_WB_reg_write), .o_write_register_WB(o_write_register_WB),
        .o_WB_write_data(o_WB_write_data), .o_load_use_stall(o_load_use_stall),
        .o_stall_cycles(o_stall_cycles)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mr, input logic [REG_W-1:0] wr,
                         input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] rs,
                         input logic [REG_W-1:0] rt, input logic fl);
        i_EX_reg_write      = rw;
        i_EX_mem_read       = mr;
        i_EX_write_register = wr;
        i_EX_alu_result     = alu;
        i_ID_Rs             = rs;
        i_ID_Rt             = rt;
        i_flush             = fl;
    endtask

    task automatic push(input logic rw, input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] d);
        wb_t e;
        e.rw = rw; e.wr = wr; e.data = d;
        wb_q.push_back(e);
    endtask

    function automatic logic model_lu();
        return i_EX_mem_read && i_EX_reg_write && (i_EX_write_register != 5'd0) &&
               ((i_EX_write_register == i_ID_Rs) || (i_EX_write_register == i_ID_Rt));
    endfunction

    // One clock: predict the counter, advance, then retire the oldest WB entry.
    task automatic step();
        logic ev, stalled;
        wb_t  e;
        ev      = model_lu() || i_MEM_stall;
        stalled = i_MEM_stall;
        @(posedge i_clk);
        @(negedge i_clk);
        if (ev && cnt_exp < CNT_TOP) cnt_exp++;
        chk("stall_cycles", 32'(o_stall_cycles), 32'(cnt_exp));
        if (!stalled && wb_q.size() >= 2) begin
            e = wb_q.pop_front();
            chk("wb_reg_write", 32'(o_MEM_WB_reg_write), 32'(e.rw));
            if (e.rw) begin
                chk("wb_write_reg", 32'(o_write_register_WB), 32'(e.wr));
                chk("wb_write_data", o_WB_write_data, e.data);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_MEM_stall = 1'b0;
        i_MEM_read_data = 32'h0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        #12;
        chk("rst_exmem_rw", 32'(o_EX_MEM_reg_write), 32'h0);
        chk("rst_exmem_mr", 32'(o_EX_MEM_mem_read), 32'h0);
        chk("rst_mem_alu", o_MEM_alu_result, 32'h0);
        chk("rst_memwb_rw", 32'(o_MEM_WB_reg_write), 32'h0);
        chk("rst_wb_data", o_WB_write_data, 32'h0);
        chk("rst_lu", 32'(o_load_use_stall), 32'h0);
        chk("rst_cnt", 32'(o_stall_cycles), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        chk("post_rst_exmem_rw", 32'(o_EX_MEM_reg_write), 32'h0);

        // ALU op to r5
        drive(1'b1, 1'b0, 5'd5, 32'h1234, 5'd0, 5'd0, 1'b0);
        push(1'b1, 5'd5, 32'h1234);
        step();
        chk("alu_mem_rw", 32'(o_EX_MEM_reg_write), 32'h1);
        chk("alu_mem_wr", 32'(o_write_register_MEM), 32'h5);
        chk("alu_mem_res", o_MEM_alu_result, 32'h1234);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        push(1'b0, 5'd0, 32'h0);
        step();

        // write to $0 is never a valid write
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF, 5'd0, 5'd0, 1'b0);
        push(1'b0, 5'd0, 32'hFFFF);
        step();
        chk("r0_mem_rw", 32'(o_EX_MEM_reg_write), 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        push(1'b0, 5'd0, 32'h0);
        step();

        // load to r8 with a dependent ID instruction
        drive(1'b1, 1'b1, 5'd8, 32'h100, 5'd0, 5'd8, 1'b0);
        #1 chk("lu_hit_rt", 32'(o_load_use_stall), 32'h1);
        push(1'b1, 5'd8, 32'hCAFE);
        step();
        drive(1'b1, 1'b0, 5'd3, 32'h77, 5'd0, 5'd0, 1'b1);
        i_MEM_read_data = 32'hCAFE;
        #1 chk("lu_clear", 32'(o_load_use_stall), 32'h0);
        push(1'b0, 5'd3, 32'h77);
        step();
        chk("flush_mem_rw", 32'(o_EX_MEM_reg_write), 32'h0);
        chk("flush_mem_mr", 32'(o_EX_MEM_mem_read), 32'h0);

        // independent load to r10, then a 3-cycle memory stall with flush on top
        drive(1'b1, 1'b1, 5'd10, 32'h200, 5'd9, 5'd9, 1'b0);
        #1 chk("lu_miss", 32'(o_load_use_stall), 32'h0);
        push(1'b1, 5'd10, 32'hBEEF);
        step();
        chk("ld2_mem_mr", 32'(o_EX_MEM_mem_read), 32'h1);
        i_MEM_stall = 1'b1;
        i_MEM_read_data = 32'h1111;
        drive(1'b1, 1'b0, 5'd12, 32'h999, 5'd0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_mem_rw", 32'(o_EX_MEM_reg_write), 32'h1);
            chk("hold_mem_mr", 32'(o_EX_MEM_mem_read), 32'h1);
            chk("hold_mem_wr", 32'(o_write_register_MEM), 32'd10);
            chk("hold_mem_alu", o_MEM_alu_result, 32'h200);
            chk("hold_wb_rw", 32'(o_MEM_WB_reg_write), 32'h0);
        end
        chk("cnt_after_stall", 32'(o_stall_cycles), 32'd4);
        i_MEM_stall = 1'b0;
        i_MEM_read_data = 32'hBEEF;
        drive(1'b1, 1'b0, 5'd4, 32'h44, 5'd0, 5'd0, 1'b0);
        push(1'b1, 5'd4, 32'h44);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        push(1'b0, 5'd0, 32'h0);
        step();

        // drive the counter to saturation
        i_MEM_stall = 1'b1;
        for (int k = 0; k < 40 && cnt_exp < CNT_TOP - 1; k++) step();
        chk("cnt_near_max", 32'(o_stall_cycles), 32'(CNT_TOP - 1));
        for (int k = 0; k < 3; k++) step();
        chk("cnt_saturated", 32'(o_stall_cycles), 32'(CNT_TOP));
        i_MEM_stall = 1'b0;

        // in-flight work, then asynchronous reset between edges
        drive(1'b1, 1'b0, 5'd6, 32'h66, 5'd0, 5'd0, 1'b0);
        push(1'b1, 5'd6, 32'h66);
        step();
        drive(1'b1, 1'b0, 5'd7, 32'h77, 5'd0, 5'd0, 1'b0);
        push(1'b1, 5'd7, 32'h77);
        step();
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_exmem_rw", 32'(o_EX_MEM_reg_write), 32'h0);
        chk("arst_mem_wr", 32'(o_write_register_MEM), 32'h0);
        chk("arst_mem_alu", o_MEM_alu_result, 32'h0);
        chk("arst_memwb_rw", 32'(o_MEM_WB_reg_write), 32'h0);
        chk("arst_wb_wr", 32'(o_write_register_WB), 32'h0);
        chk("arst_wb_data", o_WB_write_data, 32'h0);
        chk("arst_cnt", 32'(o_stall_cycles), 32'h0);
        cnt_exp = 0;
        wb_q.delete();
        @(negedge i_clk);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        i_rst_n = 1'b1;
        step();
        chk("rel_exmem_rw", 32'(o_EX_MEM_reg_write), 32'h0);
        chk("rel_memwb_rw", 32'(o_MEM_WB_reg_write), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
